// File: rtl/csa_seq_multiplier.sv
// Iterative RV32M multiplier: one partial product per cycle into a 3:2 carry-save
// accumulator, then a single carry-propagate resolve. Option macro: MUL_EARLY_EXIT_EN.
module csa_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESOLVE,
    DONE
  } state_t;

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] s,
                                            input logic [PW-1:0] c,
                                            input logic [PW-1:0] p);
    return s ^ c ^ p;
  endfunction

  // Majority shifted up one place; the carry out of the top bit is dropped.
  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] s,
                                              input logic [PW-1:0] c,
                                              input logic [PW-1:0] p);
    logic [PW-1:0] maj;
    maj = (s & c) | (s & p) | (c & p);
    return {maj[PW-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t           state_q, state_n;
  logic [1:0]       op_q;
  logic             neg_q;
  logic [PW-1:0]    a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [PW-1:0]    sum_q, carry_q;
  logic [WIDTH-1:0] result_q;

  logic             a_neg, b_neg;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    product, product_s;
  logic             last_iter;

`ifdef MUL_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain above the one consumed this cycle.
  assign last_iter = (b_sh_q[WIDTH-1:1] == '0);
`else
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  logic [CW-1:0] cnt_q;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
`endif

  assign a_neg     = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && A_i[WIDTH-1];
  assign b_neg     = (op_i == OP_MULH) && B_i[WIDTH-1];
  assign partial   = b_sh_q[0] ? a_sh_q : '0;
  assign product   = sum_q + carry_q;
  assign product_s = neg_q ? (~product + 1'b1) : product;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_n = MUL;
      MUL:     if (last_iter) state_n = RESOLVE;
      RESOLVE: state_n = DONE;
      DONE:    if (ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, carry-save iteration, final resolve.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
`ifndef MUL_EARLY_EXIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            op_q    <= op_i;
            neg_q   <= a_neg ^ b_neg;
            a_sh_q  <= {{WIDTH{1'b0}}, magnitude(A_i, a_neg)};
            b_sh_q  <= magnitude(B_i, b_neg);
            sum_q   <= '0;
            carry_q <= '0;
`ifndef MUL_EARLY_EXIT_EN
            cnt_q   <= '0;
`endif
          end
        end
        MUL: begin
          sum_q   <= csa_sum(sum_q, carry_q, partial);
          carry_q <= csa_carry(sum_q, carry_q, partial);
          a_sh_q  <= a_sh_q << 1;
          b_sh_q  <= b_sh_q >> 1;
`ifndef MUL_EARLY_EXIT_EN
          cnt_q   <= cnt_q + 1'b1;
`endif
        end
        RESOLVE: begin
          result_q <= (op_q == OP_MUL) ? product_s[WIDTH-1:0] : product_s[PW-1:WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Scoreboard bench for csa_seq_multiplier: expected results queued at accept, popped at valid_o.
module tb_csa_seq_multiplier;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int acc_lat  = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               lat_q[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  csa_seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .A_i      (A_i),
    .B_i      (B_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, zb, ps;
    logic [63:0]        pu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    zb = {32'b0, b};
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00: return pu[31:0];
      2'b01: begin ps = sa * sb; return ps[63:32]; end
      2'b10: begin ps = sa * zb; return ps[63:32]; end
      default: return pu[63:32];
    endcase
  endfunction

`ifdef MUL_EARLY_EXIT_EN
  function automatic int early_iters(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] bm;
    int it;
    bm = (op == 2'b01 && b[31]) ? (~b + 32'd1) : b;
    it = 1;
    for (int i = 0; i < 32; i++) if (bm[i]) it = i + 1;
    return it;
  endfunction
`endif

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track);
    int waitc = 0;
    @(negedge clk_i);
    while (ready_o !== 1'b1 && waitc < 100) begin
      @(negedge clk_i);
      waitc++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready: ready_o=%b required 1", ready_o);
    end
    op_i = op; A_i = a; B_i = b; valid_i = 1'b1;
`ifdef MUL_EARLY_EXIT_EN
    acc_lat = early_iters(op, b) + 2;
`else
    acc_lat = WIDTH + 2;
`endif
    if (track) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(acc_lat);
    end
    @(posedge clk_i);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
    A_i = $urandom; B_i = $urandom; op_i = 2'($urandom);
  endtask

  // Called right after issue(); lat counts the accept edge as 1.
  task automatic collect(input int hold, input bit pulse);
    int lat = 1;
    logic [31:0] e;
    int el;
    while (valid_o !== 1'b1 && lat < 200) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    e  = exp_q.pop_front();
    el = lat_q.pop_front();
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL result_timeout: valid_o=%b after %0d cycles, required 1", valid_o, lat);
    end
    checks++;
    if (lat !== el) begin
      failures++;
      $display("FAIL latency: got %0d cycles required %0d", lat, el);
    end
    checks++;
    if (result_o !== e) begin
      failures++;
      $display("FAIL result: got %h required %h", result_o, e);
    end
    for (int k = 0; k < hold; k++) begin
      if (pulse && k == 4) begin
        valid_i = 1'b1; op_i = 2'b00; A_i = 32'd11; B_i = 32'd13;
      end else begin
        valid_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b1 || result_o !== e || ready_o !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: valid_o=%b ready_o=%b result_o=%h required 1/0/%h",
                 k, valid_o, ready_o, result_o, e);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("FAIL release: valid_o=%b ready_o=%b required 0/1", valid_o, ready_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = 2'b00; A_i = '0; B_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    checks++;
    if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result: got %h required 0", result_o); end
    rst_ni = 1'b1;
  endtask

  task automatic test_mul_basic();
    issue(2'b00, 32'd7, 32'd6, 1'b1);
    collect(0, 1'b0);
  endtask

  task automatic test_corner_ops();
    logic [1:0]  ops[10] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    logic [31:0] as[10]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd9,
                             32'd5, 32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h12345678};
    logic [31:0] bs[10]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd3,
                             32'd0, 32'h80000001, 32'h7FFFFFFF, 32'h00000003, 32'h0};
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      collect(0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    issue(2'b01, 32'hFFFF0000, 32'h00012345, 1'b1);
    collect(10, 1'b1);
    issue(2'b00, 32'd100, 32'd200, 1'b1);
    collect(0, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    issue(2'b00, 32'd7, 32'd6, 1'b1);
    collect(0, 1'b0);
    issue(2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset: ready_o=%b valid_o=%b result_o=%h required 1/0/0",
               ready_o, valid_o, result_o);
    end
    rst_ni = 1'b1;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (valid_o === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_no_result: valid_o high %0d cycles required 0", seen);
    end
    issue(2'b00, 32'd3, 32'd5, 1'b1);
    collect(0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      issue(2'($urandom_range(0, 3)), a, b, 1'b1);
      collect(i % 2, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int prev_cyc, prev_lat;
    for (int i = 0; i < 4; i++) begin
      issue(2'(i), $urandom, $urandom, 1'b1);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_cyc != prev_lat + 1) begin
          failures++;
          $display("FAIL throughput: accept spacing %0d required %0d", acc_cyc - prev_cyc,
                   prev_lat + 1);
        end
      end
      prev_cyc = acc_cyc;
      prev_lat = acc_lat;
      collect(0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_corner_ops();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
